// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared FSM states, next-PC selects and opcode decode for branch hazard control.
package branch_ctrl_pkg;
  typedef enum logic [1:0] {RUN, STALL, RESOLVE} state_t;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_TGT = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [4:0] XZR = 5'd31;
  localparam logic [10:0] OP_CBZ = 11'b10110100000;
  localparam logic [10:0] MSK_CBZ = 11'b11111111000;
  localparam logic [10:0] OP_BR = 11'b11010110000;
  localparam logic [10:0] MSK_BR = 11'b11111111111;
  localparam logic [10:0] OP_B = 11'b00010100000;
  localparam logic [10:0] MSK_B = 11'b11111100000;
  localparam logic [10:0] OP_BL = 11'b10010100000;
  localparam logic [10:0] MSK_BL = 11'b11111100000;
  localparam logic [10:0] OP_BLT = 11'b01010100000;
  localparam logic [10:0] MSK_BLT = 11'b11111111000;
  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val, input logic [10:0] msk);
    return (op & msk) == val;
  endfunction
endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: load-use stall and next-PC/flush control for branches resolved in ID.
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [10:0]      id_opcode,
  input  logic [4:0]       id_src_reg,
  input  logic             br_taken,
  input  logic             uncond_br,
  input  logic             pc_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state;
  logic reg_br, hz_ex, hz_mem, stall;
  logic [1:0] redir_sel;
  assign reg_br = id_valid && (op_match(id_opcode, OP_CBZ, MSK_CBZ) || op_match(id_opcode, OP_BR, MSK_BR))
                  && id_src_reg != XZR;
  assign hz_ex = reg_br && ex_mem_read && ex_rd == id_src_reg;
  assign hz_mem = reg_br && mem_mem_read && mem_rd == id_src_reg;
  // A load in EX needs two stall cycles before ID can see its data, a load in MEM only one.
  assign stall = state == STALL || (state == RUN && (hz_ex || hz_mem));
  assign redir_sel = !id_valid ? PC_SEQ : pc_rd ? PC_REG : (br_taken || uncond_br) ? PC_TGT : PC_SEQ;
  always_comb begin
    pc_wr_en = !reset && !stall;
    ifid_wr_en = !reset && !stall;
    idex_bubble = reset || stall;
    pc_sel = (reset || stall) ? PC_SEQ : redir_sel;
    ifid_flush = reset || (DELAY_SLOT == 0 && pc_sel != PC_SEQ);
  end
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= state == RUN ? (hz_ex ? STALL : hz_mem ? RESOLVE : RUN) : state == STALL ? RESOLVE : RUN;
  sat_counter #(.WIDTH(CNT_W)) u_stall (.clk(clk), .reset(reset), .inc(!reset && !pc_wr_en), .count(stall_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_flush (.clk(clk), .reset(reset), .inc(!reset && pc_sel != PC_SEQ), .count(flush_cnt));
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed plus random stimulus against a stall-countdown reference model.
module tb_branch_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic id_valid = 0, br_taken = 0, uncond_br = 0, pc_rd = 0, ex_mem_read = 0, mem_mem_read = 0;
  logic [10:0] id_opcode = '0;
  logic [4:0] id_src_reg = '0, ex_rd = '0, mem_rd = '0;
  logic pc_wr_en_a, ifid_wr_en_a, ifid_flush_a, idex_bubble_a;
  logic pc_wr_en_b, ifid_wr_en_b, ifid_flush_b, idex_bubble_b;
  logic [1:0] pc_sel_a, pc_sel_b;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [3:0] stall_cnt_b, flush_cnt_b;
  int vecs = 0, errs = 0;
  int pend = 0, m_stall = 0, m_fa = 0, m_fb = 0;
  bit resolve = 0;
  logic e_pcw, e_bub, e_fa, e_fb;
  logic [1:0] e_sel;
  localparam logic [10:0] CBZ = 11'b10110100000, BR = 11'b11010110000, B = 11'b00010100000;
  localparam logic [10:0] BL = 11'b10010100000, BLT = 11'b01010100000, ADD = 11'b10001011000;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_src_reg(id_src_reg),
    .br_taken(br_taken), .uncond_br(uncond_br), .pc_rd(pc_rd), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .pc_wr_en(pc_wr_en_a), .ifid_wr_en(ifid_wr_en_a),
    .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a), .pc_sel(pc_sel_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  branch_hazard_ctrl #(.DELAY_SLOT(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_src_reg(id_src_reg),
    .br_taken(br_taken), .uncond_br(uncond_br), .pc_rd(pc_rd), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .pc_wr_en(pc_wr_en_b), .ifid_wr_en(ifid_wr_en_b),
    .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b), .pc_sel(pc_sel_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v, input logic [10:0] op, input logic [4:0] src, input logic bt,
                     input logic ub, input logic prd, input logic exm, input logic [4:0] exr,
                     input logic mm, input logic [4:0] mr);
    id_valid = v; id_opcode = op; id_src_reg = src; br_taken = bt; uncond_br = ub; pc_rd = prd;
    ex_mem_read = exm; ex_rd = exr; mem_mem_read = mm; mem_rd = mr;
  endtask

  task automatic cycle();
    bit regdep, hx, hm, hold;
    int total;
    @(negedge clk);
    regdep = id_valid && (id_opcode[10:3] == 8'b10110100 || id_opcode == 11'b11010110000) && id_src_reg != 5'd31;
    hx = regdep && ex_mem_read && ex_rd == id_src_reg;
    hm = regdep && mem_mem_read && mem_rd == id_src_reg;
    hold = pend > 0 || (!resolve && (hx || hm));
    e_sel = (!id_valid || hold || reset) ? 2'b00 : pc_rd ? 2'b10 : (br_taken || uncond_br) ? 2'b01 : 2'b00;
    e_pcw = !reset && !hold;
    e_bub = reset || hold;
    e_fa = reset;
    e_fb = reset || e_sel != 2'b00;
    chk("pc_wr_en", pc_wr_en_a, e_pcw);
    chk("ifid_wr_en", ifid_wr_en_a, e_pcw);
    chk("idex_bubble", idex_bubble_a, e_bub);
    chk("pc_sel", pc_sel_a, e_sel);
    chk("ifid_flush_ds1", ifid_flush_a, e_fa);
    chk("ifid_flush_ds0", ifid_flush_b, e_fb);
    chk("pc_sel_ds0", pc_sel_b, e_sel);
    chk("stall_cnt", stall_cnt_a, m_stall);
    chk("flush_cnt", flush_cnt_a, m_fa);
    chk("flush_cnt_w4", flush_cnt_b, m_fb);
    if (reset) begin
      pend = 0; resolve = 0; m_stall = 0; m_fa = 0; m_fb = 0;
    end else begin
      if (pend > 0) begin
        pend--; resolve = pend == 0;
      end else if (!resolve && (hx || hm)) begin
        total = hx ? 2 : 1;
        pend = total - 1; resolve = pend == 0;
      end else resolve = 0;
      if (!e_pcw) m_stall = m_stall < 65535 ? m_stall + 1 : m_stall;
      if (e_sel != 2'b00) begin
        m_fa = m_fa < 65535 ? m_fa + 1 : m_fa;
        m_fb = m_fb < 15 ? m_fb + 1 : m_fb;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] ops [6];
    ops = '{CBZ, BR, B, BL, BLT, ADD};
    reset = 1; set(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("rst_stall_cnt", stall_cnt_a, 0);
    reset = 0;
    cycle();
    // LDUR X3 in EX, then MEM, then operand ready with branch taken
    set(1, CBZ, 3, 0, 0, 0, 1, 3, 0, 0); cycle();
    set(1, CBZ, 3, 0, 0, 0, 0, 0, 1, 3); cycle();
    set(1, CBZ, 3, 1, 0, 0, 0, 0, 0, 0); cycle();
    set(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("ex_hz_stall_cnt", stall_cnt_a, 2);
    chk("ex_hz_flush_cnt", flush_cnt_a, 1);
    // LDUR X5 in MEM with BR X5; resolve cycle must ignore the stale hazard inputs
    set(1, BR, 5, 0, 0, 1, 0, 0, 1, 5); cycle();
    cycle();
    set(1, BR, 5, 0, 0, 1, 0, 0, 0, 0); cycle();
    set(1, CBZ, 31, 0, 0, 0, 1, 31, 0, 0); cycle();
    set(1, CBZ, 3, 0, 0, 0, 0, 3, 0, 0); cycle();
    set(1, BLT, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    set(1, B, 0, 0, 1, 0, 0, 0, 0, 0); cycle();
    set(1, BL, 0, 0, 1, 0, 0, 0, 0, 0); cycle();
    set(1, ADD, 3, 0, 0, 0, 1, 3, 0, 0); cycle();
    set(0, CBZ, 3, 1, 1, 1, 1, 3, 1, 3); cycle();
    set(1, BR, 4, 1, 0, 1, 0, 0, 0, 0); cycle();
    // reset during the second stall cycle
    set(1, CBZ, 7, 1, 0, 0, 1, 7, 0, 0); cycle();
    reset = 1; cycle();
    reset = 0; set(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("post_rst_stall_cnt", stall_cnt_a, 0);
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 59) == 0;
      set($urandom_range(0, 7) != 0, ops[$urandom_range(0, 5)] | 11'($urandom_range(0, 7)),
          $urandom_range(0, 9) == 0 ? 5'd31 : 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
      cycle();
    end
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      set(1, B, 0, 0, 1, 0, 0, 0, 0, 0); cycle();
    end
    chk("flush_sat_w4", flush_cnt_b, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
